// File: rtl/keypad_pkg.sv
// Shared types and key-code constants for the matrix keypad scanner and
// the decimal entry accumulator.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] KEY_A     = 4'd3;
    localparam logic [3:0] KEY_B     = 4'd7;
    localparam logic [3:0] KEY_C     = 4'd11;
    localparam logic [3:0] KEY_POINT = 4'd12;
    localparam logic [3:0] KEY_CLEAR = 4'd14;
    localparam logic [3:0] KEY_ENTER = 4'd15;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] digit;
    } digit_t;

    // Rows 0..2 x cols 0..2 hold 1..9 in telephone order; "0" sits at row 3, col 1.
    function automatic digit_t digit_lookup(input logic [3:0] code);
        digit_t d;
        d.is_digit = 1'b0;
        d.digit    = 4'd0;
        if (code == 4'd13) begin
            d.is_digit = 1'b1;
        end else if (code[1:0] != 2'd3 && code[3:2] != 2'd3) begin
            d.is_digit = 1'b1;
            d.digit    = {2'b00, code[3:2]} * 4'd3 + {2'b00, code[1:0]} + 4'd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: tick generator, row synchroniser, column
// rotation and press/release debounce. Emits one key_valid per accepted press.
module keypad_scan #(
    parameter int TICK_CYCLES    = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       press,
    output logic [3:0] press_code
);
    import keypad_pkg::*;

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

    scan_state_t   state, state_nx;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    row_meta, row_sync;
    logic          col_on;
    logic [1:0]    col_idx, row_lat, row_first;
    logic [DW-1:0] db_cnt;
    logic          row_hit, row_held, rows_clear;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) tick_cnt <= '0;
        else            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        row_first = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (!row_sync[r]) row_first = 2'(r);
    end

    assign row_hit    = ~&row_sync;
    assign row_held   = ~row_sync[row_lat];
    assign rows_clear = &row_sync;
    // No column is driven until the first tick after reset.
    assign key_col    = col_on ? ~(4'b0001 << col_idx) : 4'b1111;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) state <= SCAN;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SCAN:     if (tick && col_on && row_hit) state_nx = DEBOUNCE;
            DEBOUNCE: if (tick) begin
                          if (!row_held)               state_nx = SCAN;
                          else if (db_cnt == DB_LAST)  state_nx = PRESSED;
                      end
            PRESSED:  state_nx = RELEASE;
            RELEASE:  if (tick && rows_clear && db_cnt == DB_LAST) state_nx = SCAN;
            default:  state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            col_on  <= 1'b0;
            col_idx <= 2'd0;
            row_lat <= 2'd0;
            db_cnt  <= '0;
        end else begin
            case (state)
                SCAN: if (tick) begin
                    if (col_on && row_hit) begin
                        row_lat <= row_first;
                        db_cnt  <= '0;
                    end else begin
                        col_on  <= 1'b1;
                        col_idx <= col_on ? col_idx + 2'd1 : 2'd0;
                    end
                end
                DEBOUNCE: if (tick) begin
                    if (row_held) db_cnt  <= db_cnt + DW'(1);
                    else          col_idx <= col_idx + 2'd1;
                end
                PRESSED: db_cnt <= '0;
                RELEASE: if (tick) db_cnt <= rows_clear ? db_cnt + DW'(1) : '0;
                default: ;
            endcase
        end
    end

    assign press      = (state == PRESSED);
    assign press_code = {row_lat, col_idx};

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= press;
            if (press) key_code <= press_code;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front end: scans the matrix and accumulates a 0..9999 decimal
// value with a single decimal point, ready for the 4-digit display driver.
module keypad_entry #(
    parameter int TICK_CYCLES    = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] value,
    output logic [3:0]  point,
    output logic        entry_done
);
    import keypad_pkg::*;

    logic        press;
    logic [3:0]  press_code;
    logic [2:0]  count, count_nx;
    logic        new_entry, new_entry_nx;
    logic [15:0] value_nx;
    logic [3:0]  point_nx;
    logic        done_nx;
    logic [16:0] prod;
    digit_t      lk;

    keypad_scan #(
        .TICK_CYCLES   (TICK_CYCLES),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_scan (
        .clk       (clk),
        .sys_reset (sys_reset),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .press     (press),
        .press_code(press_code)
    );

    // Actions land on the same edge that registers key_valid.
    always_comb begin
        value_nx     = value;
        point_nx     = point;
        count_nx     = count;
        new_entry_nx = new_entry;
        done_nx      = 1'b0;
        prod         = '0;
        lk           = digit_lookup(press_code);
        if (press) begin
            // After ENTER the shown value stays until the next digit or point starts over.
            if ((lk.is_digit || press_code == KEY_POINT) && new_entry) begin
                value_nx     = 16'd0;
                point_nx     = 4'd0;
                count_nx     = 3'd0;
                new_entry_nx = 1'b0;
            end
            if (lk.is_digit) begin
                prod = {1'b0, value_nx} * 17'd10 + {13'd0, lk.digit};
                if (count_nx < 3'd4 && !point_nx[3] && prod <= 17'd9999) begin
                    value_nx = prod[15:0];
                    point_nx = point_nx << 1;
                    count_nx = count_nx + 3'd1;
                end
            end else begin
                case (press_code)
                    KEY_POINT: if (point_nx == 4'd0 && count_nx != 3'd0) point_nx = 4'b0001;
                    KEY_CLEAR: begin
                        value_nx = 16'd0;
                        point_nx = 4'd0;
                        count_nx = 3'd0;
                    end
                    KEY_ENTER: begin
                        done_nx      = 1'b1;
                        new_entry_nx = 1'b1;
                    end
                    KEY_A, KEY_B, KEY_C: ;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            value      <= 16'd0;
            point      <= 4'd0;
            count      <= 3'd0;
            new_entry  <= 1'b0;
            entry_done <= 1'b0;
        end else begin
            value      <= value_nx;
            point      <= point_nx;
            count      <= count_nx;
            new_entry  <= new_entry_nx;
            entry_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboarded bench for keypad_entry: a keypad model drives rows from the
// scanned column, a reference model predicts each accepted key's outcome.
module tb_keypad_entry;
    localparam int TICK = 10;
    localparam int DB   = 3;

    logic        clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic [3:0]  key_row, key_col, key_code, point;
    logic        key_valid, entry_done;
    logic [15:0] value;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    keypad_entry #(.TICK_CYCLES(TICK), .DEBOUNCE_TICKS(DB)) dut (
        .clk(clk), .sys_reset(sys_reset), .key_row(key_row), .key_col(key_col),
        .key_code(key_code), .key_valid(key_valid), .value(value), .point(point),
        .entry_done(entry_done)
    );

    // A held key shorts its row to the column currently driven low.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] val;
        logic [3:0]  pt;
        logic        done;
    } exp_t;

    exp_t sb[$];
    bit   wres[$];
    int   checks = 0, errors = 0, nvalid = 0, rcyc;
    bit   col_chk = 1'b0;

    // 0..9 digit, -1 letter, 10 point, 11 clear, 12 enter
    int kmap[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, 10, 0, 11, 12};
    int digs[$];
    int pt_pos;
    bit new_ent;

    always @(posedge clk or negedge sys_reset)
        if (!sys_reset) rcyc <= 0;
        else            rcyc <= rcyc + 1;

    function automatic logic [3:0] exp_col(input int n);
        logic [3:0] one;
        int k;
        one = 4'b0001;
        if (n < TICK) return 4'b1111;
        k = ((n / TICK) - 1) % 4;
        return ~(one << k);
    endfunction

    task automatic model_reset();
        digs.delete();
        pt_pos  = -1;
        new_ent = 1'b0;
    endtask

    task automatic model_apply(input int code, output exp_t e);
        int k, v;
        k = kmap[code];
        e.done = 1'b0;
        if (k >= 0 && k <= 10 && new_ent) begin
            digs.delete();
            pt_pos  = -1;
            new_ent = 1'b0;
        end
        if (k >= 0 && k <= 9) begin
            if (digs.size() < 4) digs.push_back(k);
        end else if (k == 10) begin
            if (pt_pos < 0 && digs.size() > 0) pt_pos = digs.size();
        end else if (k == 11) begin
            digs.delete();
            pt_pos = -1;
        end else if (k == 12) begin
            new_ent = 1'b1;
            e.done  = 1'b1;
        end
        v = 0;
        foreach (digs[i]) v = v * 10 + digs[i];
        e.code = code[3:0];
        e.val  = v[15:0];
        e.pt   = (pt_pos < 0) ? 4'd0 : 4'(1 << (digs.size() - pt_pos));
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        bit   r;
        if (!sys_reset) begin
            checks++;
            if (key_col !== 4'hF || key_code !== 4'd0 || key_valid !== 1'b0 ||
                value !== 16'd0 || point !== 4'd0 || entry_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state col=%b code=%0d valid=%b value=%0d point=%b done=%b required col=1111 code=0 valid=0 value=0 point=0000 done=0",
                         key_col, key_code, key_valid, value, point, entry_done);
            end
        end else begin
            if (col_chk) begin
                checks++;
                if (key_col !== exp_col(rcyc)) begin
                    errors++;
                    $display("FAIL idle_scan cycle=%0d col=%b required %b", rcyc, key_col, exp_col(rcyc));
                end
            end
            if (key_valid) begin
                nvalid++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_key_valid code=%0d value=%0d required no pulse", key_code, value);
                end else begin
                    e = sb.pop_front();
                    if (key_code !== e.code || value !== e.val || point !== e.pt || entry_done !== e.done) begin
                        errors++;
                        $display("FAIL key_event code=%0d value=%0d point=%b done=%b required code=%0d value=%0d point=%b done=%b",
                                 key_code, value, point, entry_done, e.code, e.val, e.pt, e.done);
                    end
                end
            end else if (entry_done) begin
                checks++;
                errors++;
                $display("FAIL stray_entry_done done=%b required 0 without key_valid", entry_done);
            end
        end
        if (wres.size() > 0) begin
            r = wres.pop_front();
            checks++;
            if (!r) begin
                errors++;
                $display("FAIL wait_bound got timeout required event within budget");
            end
        end
    end

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int start);
        int i;
        i = 0;
        while (nvalid == start && i < 400) begin
            tick_clk(1);
            i++;
        end
        wres.push_back(nvalid != start);
        if (nvalid == start) sb.delete();
    endtask

    task automatic press(input int code, input int bounce, input logic [15:0] extra);
        exp_t e;
        int   start;
        model_apply(code, e);
        sb.push_back(e);
        start = nvalid;
        repeat (bounce) begin
            held[code] = 1'b1; tick_clk(4);
            held[code] = 1'b0; tick_clk(4);
        end
        held = held | extra;
        held[code] = 1'b1;
        wait_valid(start);
        tick_clk(40);
        repeat (bounce) begin
            held[code] = 1'b0; tick_clk(3);
            held[code] = 1'b1; tick_clk(3);
        end
        held = '0;
        tick_clk(60);
    endtask

    int seq[] = '{14, 0, 1, 12, 2, 4, 8,       // CLEAR 1 2 . 3 4 7
                  14, 12, 0, 12, 12,           // CLEAR . 1 . .
                  14, 10, 10, 15, 2, 14};      // CLEAR 9 9 ENTER 3 CLEAR

    initial begin : stim
        exp_t e;
        int   start, i;
        model_reset();
        tick_clk(3);
        sys_reset = 1'b1;
        col_chk   = 1'b1;
        tick_clk(100);
        col_chk   = 1'b0;

        press(5, 2, '0);
        foreach (seq[j]) press(seq[j], int'($urandom_range(0, 1)), '0);

        // Two keys in one column: the lower row index is reported.
        press(0, 0, 16'h0010);

        // A key in another column held across RELEASE is seen only afterwards.
        model_apply(5, e);
        sb.push_back(e);
        start = nvalid;
        held[5] = 1'b1;
        wait_valid(start);
        tick_clk(10);
        held[2] = 1'b1;
        tick_clk(40);
        model_apply(2, e);
        sb.push_back(e);
        start = nvalid;
        held[5] = 1'b0;
        wait_valid(start);
        tick_clk(30);
        held = '0;
        tick_clk(60);

        for (int n = 0; n < 30; n++)
            press(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), '0);

        // Reset while key "8" is being debounced.
        press(8, 0, '0);
        held[9] = 1'b1;
        i = 0;
        while (key_col !== 4'b1101 && i < 200) begin
            tick_clk(1);
            i++;
        end
        wres.push_back(key_col === 4'b1101);
        tick_clk(20);
        sys_reset = 1'b0;
        model_reset();
        tick_clk(3);
        held = '0;
        sys_reset = 1'b1;
        tick_clk(100);

        press(1, 0, '0);
        tick_clk(20);
        wres.push_back(sb.size() == 0);
        tick_clk(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart to the 4-digit multiplexed display driver.
- Scans a 4x4 active-low matrix keypad and debounces key presses.
- Decodes each press to a key code and assembles a decimal entry of 0..9999 with one decimal point.
- The value and point outputs connect directly to the display driver's data[15:0] and point[3:0] inputs, for fare or rate entry in the taxi-fare system.

Parameters:
TICK_CYCLES, 50000, clk cycles per scan tick (1 ms at 50 MHz)
DEBOUNCE_TICKS, 20, consecutive stable ticks required for press and for release

Ports:
clk  input  1  system clock, 50 MHz
sys_reset  input  1  asynchronous active-low reset
key_row  input  4  keypad rows, active low, externally pulled up, asynchronous to clk
key_col  output  4  column drive, active low, one-hot-low while scanning
key_code  output  4  code of last accepted key, {row[1:0],col[1:0]}
key_valid  output  1  one-clk pulse when a debounced press is accepted
value  output  16  binary entry value, 0..9999
point  output  4  decimal point position, bit0 = units digit, at most one bit set
entry_done  output  1  one-clk pulse when ENTER is accepted

Behaviour:
Reset values (sys_reset low, asynchronous):
- key_col=4'b1111, key_code=0, key_valid=0, value=0, point=0, entry_done=0.
- FSM=SCAN; tick counter, debounce counter, digit count and new_entry flag all cleared.

Synchronisation and tick:
- key_row passes through a 2-flop synchroniser; only the synchronised copy is used.
- tick is a one-clk pulse every TICK_CYCLES clk. The counter runs freely from reset.

FSM (all state changes happen on tick only, except the key_valid pulse):
- SCAN:
  - On each tick, sample rows for the currently driven column.
  - If any row is low, latch row (lowest-index low row wins) and col, clear the debounce counter, and go to DEBOUNCE.
  - Otherwise rotate the column: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - The first tick after reset drives 1110.
- DEBOUNCE:
  - The column is held.
  - If the latched row is still low, increment the counter. At DEBOUNCE_TICKS, go to PRESSED.
  - If the latched row is high, return to SCAN and advance the column.
- PRESSED:
  - key_code and key_valid are registered one clk after entry, so latency from the qualifying tick is 1 clk.
  - The key action is applied in the same clk.
  - Next state is RELEASE.
- RELEASE:
  - The column is held.
  - Count ticks with all synchronised rows high. Any low row clears the count.
  - At DEBOUNCE_TICKS, go to SCAN. No auto-repeat.

Key map, code = row*4+col:
- Row 0: 1, 2, 3, A
- Row 1: 4, 5, 6, B
- Row 2: 7, 8, 9, C
- Row 3: POINT, 0, CLEAR, ENTER

Key actions (applied in PRESSED):
- If new_entry=1, any digit or POINT first clears value, point and count, and clears new_entry.
- Digit d:
  - If count<4: value <= value*10 + d (17-bit intermediate, result always <=9999), point <= point<<1, count++.
  - If count=4: ignored. key_valid still pulses.
- POINT:
  - If point==0 and count>0: point <= 4'b0001.
  - Otherwise ignored; only one point is allowed.
  - If a later digit would shift the point beyond bit3, that digit is ignored. This cannot occur when count<=4.
- CLEAR: value=0, point=0, count=0.
- ENTER: entry_done pulses for one clk, value and point are held, new_entry=1.
- A, B, C: key_valid and key_code only; value is unaffected.

Boundaries:
- Multiple keys in the same column: lowest row wins.
- A key in a different column pressed during RELEASE is not seen until release completes.
- Reset mid-debounce aborts with no key_valid.
- value never exceeds 9999.

Decomposition:
- Package keypad_pkg contains:
  - State encoding: SCAN, DEBOUNCE, PRESSED, RELEASE.
  - Key-code constants: KEY_A=3, KEY_B=7, KEY_C=11, KEY_POINT=12, KEY_CLEAR=14, KEY_ENTER=15.
  - Digit lookup function from code to digit value plus an is_digit flag.
- Sub-module keypad_scan contains the tick generator, synchroniser, column drive, FSM and debounce. Its outputs are key_code and key_valid.
- The top level keypad_entry adds the entry accumulator (value, point, count, new_entry, entry_done).

Test Plan (TICK_CYCLES=10, DEBOUNCE_TICKS=3, keypad model ties row low when its column is driven):
- Reset, then idle 100 clk -> key_col cycles 1110/1101/1011/0111 every 10 clk; key_valid never asserts.
- Press key "5" with 2 ticks of bounce, then stable -> exactly one key_valid with key_code=5; value=5; no second pulse while held or on bouncy release.
- Enter 1,2,POINT,3,4 -> value=1234, point=4'b0100; fifth digit 7 -> value stays 1234, key_valid still pulses.
- POINT as the first key -> point=0; a second POINT after "1,POINT" -> point stays 4'b0001.
- 9,9,ENTER -> entry_done is a 1-clk pulse with value=99; then 3 -> value=3, point=0; CLEAR -> value=0.
- Assert sys_reset low mid-DEBOUNCE -> all outputs return to reset values immediately; key_valid stays 0.
